// File: rtl/uart_rx_if.sv
// Serial line into the UART receiver and the received-byte strobes out of it.
// The receiver uses the slave modport; whoever drives the line uses master.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output rx,
        input  data,
        input  valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  rx,
        output data,
        output valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling from a free-running fractional tick,
// three-sample majority vote at mid-bit, one-cycle valid / frame_error strobes.
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int OS_ACC_WIDTH = 16,
    parameter int OS_INC       = ((BAUD << (OS_ACC_WIDTH - 7)) + (CLK_FREQ >> 12)) / (CLK_FREQ >> 11)
) (
    input  logic      clk,
    input  logic      reset_n,
    uart_rx_if.slave  bus
);

    localparam logic [OS_ACC_WIDTH:0] INC_W = (OS_ACC_WIDTH + 1)'(OS_INC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic [OS_ACC_WIDTH:0] acc_q, acc_d;
    logic                  tick;
    logic                  rx_meta_q, rx_s_q;
    logic [3:0]            os_cnt_q, os_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [2:0]            samp_q, samp_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  wrap;
    logic                  vote_wrap;
    logic                  vote_stop;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The carry out of the accumulator is the 16x tick; the carry is dropped
    // on the next add so the tick is exactly one clock wide.
    assign acc_d = {1'b0, acc_q[OS_ACC_WIDTH-1:0]} + INC_W;
    assign tick  = acc_q[OS_ACC_WIDTH];

    assign wrap      = tick && (os_cnt_q == 4'd15);
    assign vote_wrap = maj3(samp_q[0], samp_q[1], samp_q[2]);
    // The stop bit is judged on the third sample as it arrives, not on the wrap.
    assign vote_stop = maj3(samp_q[0], samp_q[1], rx_s_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            samp_q    <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            samp_q    <= samp_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        samp_d    = samp_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        if (tick) begin
            case (os_cnt_q)
                4'd7:    samp_d[0] = rx_s_q;
                4'd8:    samp_d[1] = rx_s_q;
                4'd9:    samp_d[2] = rx_s_q;
                default: ;
            endcase
        end

        if (tick && (state_q == S_START || state_q == S_DATA || state_q == S_STOP)) begin
            os_cnt_d = os_cnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick && !rx_s_q) begin
                    state_d  = S_START;
                    os_cnt_d = '0;
                end
            end
            S_START: begin
                if (wrap) begin
                    bit_idx_d = '0;
                    state_d   = vote_wrap ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    shreg_d   = {vote_wrap, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && os_cnt_q == 4'd9) begin
                    if (vote_stop) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must go high again before a new start is accepted.
                if (tick && rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data        = data_q;
    assign bus.valid       = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx: frames are serialised from bytes and the
// expected stream (good bytes, frame errors, held data) is tracked at frame level.
module tb_uart_rx;
    localparam int  CLK_FREQ = 1_000_000;
    localparam int  BAUD     = 15_625;
    localparam int  BIT_CLK  = CLK_FREQ / BAUD;
    localparam real BIT_R    = 64.0;

    logic clk = 1'b0;
    logic reset_n;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed stream, sampled on the falling edge.
    int         nvalid   = 0;
    int         nferr    = 0;
    int         nboth    = 0;
    int         busy_cyc = 0;
    int         lat_last = 0;
    int         start_cyc = 0;
    logic [7:0] got_mem [0:63];

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (nvalid < 64) got_mem[nvalid] <= bus.data;
            nvalid   <= nvalid + 1;
            lat_last <= cyc - start_cyc;
        end
        if (bus.frame_error === 1'b1) nferr <= nferr + 1;
        if (bus.valid === 1'b1 && bus.frame_error === 1'b1) nboth <= nboth + 1;
        if (bus.busy === 1'b1) busy_cyc <= busy_cyc + 1;
    end

    // Reference model state.
    logic [7:0] exp_mem [0:63];
    int         n_exp      = 0;
    int         n_exp_ferr = 0;
    int         n_checked  = 0;
    logic [7:0] last_good  = 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        step(n * BIT_CLK);
    endtask

    // Serialise one 8N1 frame with an arbitrary (real) bit period; optionally
    // invert the line for one clock at the centre of every bit.
    task automatic send(input logic [7:0] b, input logic stop, input real per, input bit glitch);
        logic [9:0] bits;
        int t0, t1;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            t0 = $rtoi(i * per + 0.5);
            t1 = $rtoi((i + 1) * per + 0.5);
            if (i == 0) start_cyc = cyc;
            for (int c = 0; c < t1 - t0; c++) begin
                bus.rx = (glitch && c == (t1 - t0) / 2) ? ~bits[i] : bits[i];
                step(1);
            end
        end
        bus.rx = 1'b1;
        if (stop) begin
            if (n_exp < 64) exp_mem[n_exp] = b;
            n_exp++;
            last_good = b;
        end else begin
            n_exp_ferr++;
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "/valid_count"}, nvalid, n_exp);
        chk({tag, "/ferr_count"}, nferr, n_exp_ferr);
        chk({tag, "/valid_and_ferr"}, nboth, 0);
        for (int k = n_checked; k < n_exp && k < 64; k++) begin
            chk($sformatf("%s/byte%0d", tag, k), got_mem[k], exp_mem[k]);
        end
        n_checked = n_exp;
        chk({tag, "/data_hold"}, bus.data, last_good);
    endtask

    initial begin
        int b0, lat;
        logic [7:0] rb;

        bus.rx  = 1'b1;
        reset_n = 1'b0;
        step(5);
        chk("reset/data", bus.data, 8'h00);
        chk("reset/valid", bus.valid, 1'b0);
        chk("reset/frame_error", bus.frame_error, 1'b0);
        chk("reset/busy", bus.busy, 1'b0);
        reset_n = 1'b1;
        idle_bits(2);

        // Single frame 'a': latency around 9.56 bits, busy over before frame end.
        b0 = busy_cyc;
        send(8'h61, 1'b1, BIT_R, 1'b0);
        chk("a/busy_after_frame", bus.busy, 1'b0);
        lat = lat_last;
        chk("a/latency_window", (lat >= 600 && lat <= 630), 1'b1);
        chk("a/busy_duration", (busy_cyc - b0 >= 580 && busy_cyc - b0 <= 630), 1'b1);
        idle_bits(2);
        check_stream("a");

        // Back-to-back frames, no idle between stop and next start.
        send(8'h00, 1'b1, BIT_R, 1'b0);
        send(8'hFF, 1'b1, BIT_R, 1'b0);
        send(8'h55, 1'b1, BIT_R, 1'b0);
        send(8'hA5, 1'b1, BIT_R, 1'b0);
        idle_bits(2);
        check_stream("b2b");

        // Short low pulse: false start, discarded without a strobe.
        bus.rx = 1'b0;
        step(15);
        bus.rx = 1'b1;
        step(80);
        chk("glitch/busy", bus.busy, 1'b0);
        idle_bits(1);
        check_stream("glitch");

        // Bad stop bit, line held low (break), then a good frame.
        send(8'h3C, 1'b0, BIT_R, 1'b0);
        bus.rx = 1'b0;
        step(3 * BIT_CLK);
        chk("break/busy_while_low", bus.busy, 1'b1);
        idle_bits(2);
        check_stream("ferr");
        send(8'h7E, 1'b1, BIT_R, 1'b0);
        idle_bits(2);
        check_stream("after_ferr");

        // +-2% bit period with a one-clock glitch at each bit centre.
        send(8'hC3, 1'b1, BIT_R * 0.98, 1'b1);
        idle_bits(2);
        send(8'hC3, 1'b1, BIT_R, 1'b1);
        idle_bits(2);
        send(8'hC3, 1'b1, BIT_R * 1.02, 1'b1);
        idle_bits(2);
        check_stream("skew_glitch");

        // Reset during data bit 4 of 0xF0 (bits 4..7 and stop are high, so no
        // falling edge follows the reset).
        start_cyc = cyc;
        bus.rx = 1'b0;
        step(5 * BIT_CLK);
        bus.rx = 1'b1;
        step(BIT_CLK / 2);
        chk("midreset/busy_before", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midreset/data", bus.data, 8'h00);
        chk("midreset/valid", bus.valid, 1'b0);
        chk("midreset/frame_error", bus.frame_error, 1'b0);
        chk("midreset/busy", bus.busy, 1'b0);
        step(3);
        reset_n = 1'b1;
        last_good = 8'h00;
        idle_bits(6);
        check_stream("midreset");
        send(8'h12, 1'b1, BIT_R, 1'b0);
        idle_bits(2);
        check_stream("after_reset");

        // Random bytes with random gaps (zero gap included) and random glitches.
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, 1'b1, BIT_R, 1'($urandom_range(0, 1)));
            step($urandom_range(0, 2) * BIT_CLK);
        end
        idle_bits(2);
        check_stream("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
